// File: rtl/accumulator_array.sv
// accumulator_array: per-column psum accumulators over channel passes with
// requantised, backpressured result output.
module accumulator_array #(
    parameter int N_COL     = 16,
    parameter int PSUM_W    = 8,
    parameter int ACC_W     = 20,
    parameter int OUT_W     = 8,
    parameter int MAX_OFMAP = 16,
    parameter int CH_W      = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_COL*PSUM_W-1:0]          psum_i,
    input  logic [N_COL-1:0]                 pvalid_i,
    output logic [N_COL-1:0]                 pready_o,
    input  logic                             cfg_start_i,
    input  logic [$clog2(MAX_OFMAP+1)-1:0]   ofmap_size_i,
    input  logic [CH_W-1:0]                  ifmap_ch_i,
    input  logic [4:0]                       shift_i,
    input  logic                             relu_en_i,
    output logic [N_COL-1:0]                 conv_valid_o,
    input  logic [N_COL-1:0]                 conv_ready_i,
    output logic [N_COL-1:0]                 conv_last_o,
    output logic [N_COL*OUT_W-1:0]           conv_result_o,
    output logic                             busy_o,
    output logic                             done_o
);
    localparam int SW    = $clog2(MAX_OFMAP + 1);
    localparam int DEPTH = MAX_OFMAP * MAX_OFMAP;
    localparam int PIX_W = $clog2(DEPTH);
    // Wide enough that a rounding offset of up to 2^30 never overflows.
    localparam int RW    = ACC_W + 33;
    localparam logic signed [RW-1:0] MAXV = RW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (OUT_W - 1)));
    localparam logic [OUT_W-1:0] MAXO = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] MINO = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, FINAL, DRAIN} state_e;

    logic [SW-1:0]     s_q;
    logic [CH_W-1:0]   c_q;
    logic [4:0]        shift_q;
    logic              relu_q, done_q;
    logic [2*SW-1:0]   last_pix;
    logic [N_COL-1:0]  col_busy, col_busy_d;
    logic              start_ok, go, first_final;

    assign start_ok    = cfg_start_i && !busy_o;
    assign go          = start_ok && ofmap_size_i != '0 && ifmap_ch_i != '0;
    assign first_final = ifmap_ch_i == CH_W'(1);
    assign last_pix    = (2*SW)'(s_q) * (2*SW)'(s_q) - (2*SW)'(1);
    assign busy_o      = |col_busy;
    assign done_o      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_q     <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (start_ok) begin
                s_q     <= ofmap_size_i;
                c_q     <= ifmap_ch_i;
                shift_q <= shift_i;
                relu_q  <= relu_en_i;
            end
            done_q <= (busy_o && !(|col_busy_d)) || (start_ok && !go);
        end
    end

    for (genvar c = 0; c < N_COL; c++) begin : g_col
        state_e                   st_q, st_d;
        logic [PIX_W-1:0]         pix_q, pix_d;
        logic [CH_W-1:0]          ch_q, ch_d;
        logic                     vld_q, vld_d, lst_q, lst_d, rdy, acc, pix_end, wr;
        logic [OUT_W-1:0]         res_q, res_d, sat;
        logic signed [ACC_W-1:0]  ps, sum;
        logic signed [RW-1:0]     wide, rnd, shd, rl;
        logic [ACC_W-1:0]         mem_q [DEPTH];

        assign ps = {{(ACC_W - PSUM_W){psum_i[c*PSUM_W+PSUM_W-1]}}, psum_i[c*PSUM_W +: PSUM_W]};

        always_comb begin
            rdy     = st_q == ACC || (st_q == FINAL && (!vld_q || conv_ready_i[c]));
            acc     = rdy && pvalid_i[c];
            pix_end = (2*SW)'(pix_q) == last_pix;
            sum     = ((st_q == ACC && ch_q == '0) || c_q == CH_W'(1)) ? ps : $signed(mem_q[pix_q]) + ps;
            wide    = RW'(sum);
            rnd     = (shift_q == '0) ? '0 : RW'(1) <<< (shift_q - 5'd1);
            shd     = (wide + rnd) >>> shift_q;
            rl      = (relu_q && shd[RW-1]) ? '0 : shd;
            sat     = (rl > MAXV) ? MAXO : (rl < MINV) ? MINO : rl[OUT_W-1:0];
            st_d    = st_q;
            pix_d   = pix_q;
            ch_d    = ch_q;
            vld_d   = (vld_q && conv_ready_i[c]) ? 1'b0 : vld_q;
            lst_d   = lst_q;
            res_d   = res_q;
            wr      = 1'b0;
            unique case (st_q)
                IDLE: if (go) begin
                    st_d  = first_final ? FINAL : ACC;
                    pix_d = '0;
                    ch_d  = '0;
                end
                ACC: if (acc) begin
                    wr    = 1'b1;
                    pix_d = pix_end ? '0 : pix_q + PIX_W'(1);
                    ch_d  = pix_end ? ch_q + CH_W'(1) : ch_q;
                    st_d  = (pix_end && ch_q == c_q - CH_W'(2)) ? FINAL : ACC;
                end
                FINAL: if (acc) begin
                    vld_d = 1'b1;
                    res_d = sat;
                    lst_d = pix_end;
                    pix_d = pix_end ? '0 : pix_q + PIX_W'(1);
                    st_d  = pix_end ? DRAIN : FINAL;
                end
                DRAIN: st_d = vld_d ? DRAIN : IDLE;
                default: st_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q  <= IDLE;
                pix_q <= '0;
                ch_q  <= '0;
                vld_q <= 1'b0;
                lst_q <= 1'b0;
                res_q <= '0;
            end else begin
                st_q  <= st_d;
                pix_q <= pix_d;
                ch_q  <= ch_d;
                vld_q <= vld_d;
                lst_q <= lst_d;
                res_q <= res_d;
            end
        end

        always_ff @(posedge clk) begin
            if (wr) mem_q[pix_q] <= sum;
        end

        assign col_busy[c]                   = st_q != IDLE;
        assign col_busy_d[c]                 = st_d != IDLE;
        assign pready_o[c]                   = rdy;
        assign conv_valid_o[c]               = vld_q;
        assign conv_last_o[c]                = lst_q;
        assign conv_result_o[c*OUT_W +: OUT_W] = res_q;
    end
endmodule

// File: tb/tb_accumulator_array.sv
// tb_accumulator_array: randomized psum streams checked against a per-pixel
// running-sum model with requantisation done in plain integer arithmetic.
module tb_accumulator_array;
    localparam int N = 16, PW = 8, AW = 20, OW = 8, MO = 16, CW = 6;
    localparam int RAND = 1000;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N*PW-1:0] psum_i;
    logic [N-1:0] pvalid_i, pready_o, conv_valid_o, conv_ready_i, conv_last_o;
    logic cfg_start_i, relu_en_i, busy_o, done_o;
    logic [4:0] ofmap_size_i, shift_i;
    logic [CW-1:0] ifmap_ch_i;
    logic [N*OW-1:0] conv_result_o;

    int checks = 0, failures = 0;
    longint accm[N][MO*MO];
    int expq[N][$];
    bit expl[N][$];
    int beats[N], outs[N];

    always #5 clk = ~clk;

    accumulator_array dut (
        .clk(clk), .rst_n(rst_n), .psum_i(psum_i), .pvalid_i(pvalid_i), .pready_o(pready_o),
        .cfg_start_i(cfg_start_i), .ofmap_size_i(ofmap_size_i), .ifmap_ch_i(ifmap_ch_i),
        .shift_i(shift_i), .relu_en_i(relu_en_i), .conv_valid_o(conv_valid_o),
        .conv_ready_i(conv_ready_i), .conv_last_o(conv_last_o), .conv_result_o(conv_result_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic longint wrap(input longint v);
        logic signed [AW-1:0] t;
        t = AW'(v);
        return longint'(t);
    endfunction

    function automatic int requant(input longint v, input int sh, input bit relu);
        longint t = v;
        if (sh > 0) t = (t + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return int'(t);
    endfunction

    task automatic model_accept(input int c, input logic [PW-1:0] p, input int s, input int ch,
                                input int sh, input bit relu);
        int np = s * s;
        int k = beats[c];
        int pix = k % np;
        longint v = longint'($signed(p));
        accm[c][pix] = (k / np == 0) ? wrap(v) : wrap(accm[c][pix] + v);
        if (k / np == ch - 1) begin
            expq[c].push_back(requant(accm[c][pix], sh, relu));
            expl[c].push_back(pix == np - 1);
        end
        beats[c]++;
    endtask

    task automatic run_layer(input int s, input int ch, input int sh, input bit relu, input int pv,
                             input int v0, input int vr, input int rr, input bit hold, input bit mid);
        int total = s * s * ch;
        int dones = 0, cyc = 0, hold_left = 0, tot_out = 0;
        bit held = 0, fin = 0, all_in;
        logic [PW-1:0] pr[N];
        logic [N*OW-1:0] snap_r;
        logic [N-1:0] snap_l, snap_v;
        for (int c = 0; c < N; c++) begin
            beats[c] = 0; outs[c] = 0; expq[c].delete(); expl[c].delete();
        end
        @(negedge clk);
        ofmap_size_i = 5'(s); ifmap_ch_i = CW'(ch); shift_i = 5'(sh); relu_en_i = relu;
        cfg_start_i = 1'b1; pvalid_i = '0; conv_ready_i = '1;
        @(negedge clk);
        cfg_start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        while (!fin && cyc < 20000) begin
            if (hold && !held && conv_valid_o != '0) begin
                held = 1; hold_left = 5;
                snap_r = conv_result_o; snap_l = conv_last_o; snap_v = conv_valid_o;
            end
            if (hold_left > 0) begin
                if (hold_left < 5) begin
                    chk("hold_result", conv_result_o, snap_r);
                    chk("hold_last", conv_last_o, snap_l);
                    chk("hold_valid", conv_valid_o, snap_v);
                end
                conv_ready_i = '0;
            end else
                for (int c = 0; c < N; c++) conv_ready_i[c] = $urandom_range(0, 99) < rr;
            for (int c = 0; c < N; c++) begin
                pvalid_i[c] = beats[c] < total && $urandom_range(0, 99) < (c == 0 ? v0 : vr);
                pr[c] = (pv == RAND) ? PW'($urandom) : PW'(pv);
                psum_i[c*PW +: PW] = pr[c];
            end
            cfg_start_i = mid && cyc == 3;
            if (mid && cyc == 3) begin ofmap_size_i = 5'd1; ifmap_ch_i = CW'(1); end
            #1;
            if (hold_left > 0) chk("hold_pready", pready_o & conv_valid_o, 0);
            for (int c = 0; c < N; c++) begin
                if (pvalid_i[c] && pready_o[c]) model_accept(c, pr[c], s, ch, sh, relu);
                if (conv_valid_o[c] && conv_ready_i[c]) begin
                    chk("out_expected", expq[c].size() > 0, 1);
                    if (expq[c].size() > 0) begin
                        chk($sformatf("result_col%0d", c), $signed(conv_result_o[c*OW +: OW]), expq[c].pop_front());
                        chk($sformatf("last_col%0d", c), conv_last_o[c], expl[c].pop_front());
                    end
                    outs[c]++;
                end
            end
            tot_out = 0;
            all_in = 1;
            for (int c = 0; c < N; c++) begin
                tot_out += outs[c];
                all_in &= beats[c] == total && outs[c] == s * s;
            end
            if (done_o) begin
                dones++;
                chk("done_after_drain", tot_out, N * s * s);
            end
            if (hold_left > 0) hold_left--;
            fin = all_in && !busy_o;
            cyc++;
            @(negedge clk);
        end
        chk("layer_complete", fin, 1);
        for (int c = 0; c < N; c++) begin
            chk($sformatf("accepts_col%0d", c), beats[c], total);
            chk($sformatf("outs_col%0d", c), outs[c], s * s);
        end
        chk("done_count", dones, 1);
        chk("done_low_after", done_o, 0);
        pvalid_i = '0; conv_ready_i = '1; cfg_start_i = 1'b0;
    endtask

    initial begin
        psum_i = '0; pvalid_i = '0; conv_ready_i = '1; cfg_start_i = 1'b0;
        ofmap_size_i = '0; ifmap_ch_i = '0; shift_i = '0; relu_en_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pready", pready_o, 0);
        chk("rst_valid", conv_valid_o, 0);
        chk("rst_last", conv_last_o, 0);
        chk("rst_result", conv_result_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst_n = 1'b1;

        // Abort a layer with results pending in the output registers.
        @(negedge clk);
        ofmap_size_i = 5'd2; ifmap_ch_i = CW'(1); shift_i = '0; relu_en_i = 1'b0; cfg_start_i = 1'b1;
        @(negedge clk);
        cfg_start_i = 1'b0; pvalid_i = '1; conv_ready_i = '0;
        for (int c = 0; c < N; c++) psum_i[c*PW +: PW] = 8'd5;
        @(negedge clk);
        chk("pre_abort_valid", conv_valid_o, {N{1'b1}});
        rst_n = 1'b0;
        #1;
        chk("abort_valid", conv_valid_o, 0);
        chk("abort_result", conv_result_o, 0);
        chk("abort_last", conv_last_o, 0);
        chk("abort_pready", pready_o, 0);
        chk("abort_busy", busy_o, 0);
        pvalid_i = '0; conv_ready_i = '1;
        @(negedge clk);
        rst_n = 1'b1;
        run_layer(2, 1, 0, 0, 5, 100, 100, 100, 0, 0);

        run_layer(2, 3, 0, 0, 1, 100, 100, 100, 0, 0);
        run_layer(1, 2, 0, 0, 100, 100, 100, 100, 0, 0);
        run_layer(1, 2, 0, 0, -100, 100, 100, 100, 0, 0);
        run_layer(1, 2, 0, 1, -100, 100, 100, 100, 0, 0);
        run_layer(1, 1, 2, 0, 6, 100, 100, 100, 0, 0);
        run_layer(1, 1, 2, 0, -6, 100, 100, 100, 0, 0);
        run_layer(2, 1, 0, 0, RAND, 100, 100, 100, 1, 0);
        run_layer(3, 3, 1, 0, RAND, 50, 100, 100, 0, 1);

        // Degenerate sizes never start any column.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ofmap_size_i = (k == 0) ? 5'd0 : 5'd2; ifmap_ch_i = (k == 0) ? CW'(3) : CW'(0);
            cfg_start_i = 1'b1;
            @(negedge clk);
            cfg_start_i = 1'b0;
            chk("zero_done", done_o, 1);
            chk("zero_busy", busy_o, 0);
            chk("zero_pready", pready_o, 0);
            @(negedge clk);
            chk("zero_done_pulse", done_o, 0);
        end

        for (int r = 0; r < 3; r++)
            run_layer($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 6),
                      1'($urandom_range(0, 1)), RAND, 70, 70, 70, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
